arf_eval_ctrl: RTL and testbench

// - Sequencer for the ARF datapath pair (approximate arf_variance, exact arf_accurate), both combinational.
// - Accepts one 10-operand sample per handshake and drives both datapaths from one registered operand bus.
// - Waits a fixed settle time, then captures both output pairs (out_27, out_28) and returns the accurate

---
 rtl/arf_pkg.sv | 43 ++++
 rtl/arf_eval_ctrl_if.sv | 24 ++
 rtl/arf_err_stats.sv | 63 ++++++
 rtl/arf_eval_ctrl.sv | 119 +++++++++++
 tb/tb_arf_eval_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arf_pkg.sv
// Shared types and constants for the ARF evaluation controller.
// Operand and output word positions match the packing of the operand and result buses.
package arf_pkg;

  localparam int WORD    = 32;
  localparam int NUM_IN  = 10;
  localparam int NUM_OUT = 2;

  // Word positions inside in_data/dp_in: in_1_0 is word 0, in_14_1 is word 9
  localparam int IDX_IN_1_0  = 0;
  localparam int IDX_IN_2_0  = 1;
  localparam int IDX_IN_3_0  = 2;
  localparam int IDX_IN_4_0  = 3;
  localparam int IDX_IN_5_0  = 4;
  localparam int IDX_IN_6_0  = 5;
  localparam int IDX_IN_7_0  = 6;
  localparam int IDX_IN_8_0  = 7;
  localparam int IDX_IN_13_1 = 8;
  localparam int IDX_IN_14_1 = 9;

  localparam int OUT_27 = 0;
  localparam int OUT_28 = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESULT
  } state_t;

  // Two's-complement magnitude; the most negative value clamps to the largest positive value
  function automatic logic [WORD-1:0] abs_sat(input logic [WORD-1:0] d);
    logic [WORD-1:0] mag;
    if (!d[WORD-1]) begin
      mag = d;
    end else if (d == {1'b1, {(WORD-1){1'b0}}}) begin
      mag = {1'b0, {(WORD-1){1'b1}}};
    end else begin
      mag = ~d + WORD'(1);
    end
    return mag;
  endfunction

endpackage

// File: rtl/arf_eval_ctrl_if.sv
// Sample-in / result-out handshake bundle of the ARF evaluation controller.
// master is the sample producer and result consumer; slave is the controller.
interface arf_eval_ctrl_if;
  import arf_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*WORD-1:0]    in_data;
  logic                      res_valid;
  logic                      res_ready;
  logic [NUM_OUT*WORD-1:0]   res_acc;
  logic [NUM_OUT*WORD-1:0]   res_diff;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_acc, res_diff
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_acc, res_diff
  );

endinterface

// File: rtl/arf_err_stats.sv
// Running error statistics for the approximation study: peak |d|, saturating sum of |d|, sample count.
// Statistics move only on a capture pulse; a clear on the same edge takes priority.
module arf_err_stats
  import arf_pkg::*;
#(
  parameter int SUM_W = 48,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture_i,
  input  logic                    clear_i,
  input  logic [NUM_OUT*WORD-1:0] diff_i,
  output logic [WORD-1:0]         err_max_o,
  output logic [SUM_W-1:0]        err_sum_o,
  output logic [CNT_W-1:0]        sample_cnt_o
);

  logic [WORD-1:0]  errMax_q, errMax_d;
  logic [SUM_W-1:0] errSum_q, errSum_d;
  logic [CNT_W-1:0] sampleCnt_q, sampleCnt_d;

  logic [WORD-1:0]  mag27, mag28, peak;
  logic [SUM_W:0]   sumWide;

  // One spare bit on the sum exposes the carry used for saturation
  always_comb begin
    mag27   = abs_sat(diff_i[OUT_27*WORD +: WORD]);
    mag28   = abs_sat(diff_i[OUT_28*WORD +: WORD]);
    peak    = (mag27 > mag28) ? mag27 : mag28;
    sumWide = {1'b0, errSum_q} + (SUM_W+1)'(mag27) + (SUM_W+1)'(mag28);

    errMax_d    = errMax_q;
    errSum_d    = errSum_q;
    sampleCnt_d = sampleCnt_q;
    if (clear_i) begin
      errMax_d    = '0;
      errSum_d    = '0;
      sampleCnt_d = '0;
    end else if (capture_i) begin
      errMax_d    = (peak > errMax_q) ? peak : errMax_q;
      errSum_d    = sumWide[SUM_W] ? {SUM_W{1'b1}} : sumWide[SUM_W-1:0];
      sampleCnt_d = sampleCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errMax_q    <= '0;
      errSum_q    <= '0;
      sampleCnt_q <= '0;
    end else begin
      errMax_q    <= errMax_d;
      errSum_q    <= errSum_d;
      sampleCnt_q <= sampleCnt_d;
    end
  end

  assign err_max_o    = errMax_q;
  assign err_sum_o    = errSum_q;
  assign sample_cnt_o = sampleCnt_q;

endmodule

// File: rtl/arf_eval_ctrl.sv
// Sequencer for the approximate/accurate ARF datapath pair: launches one sample, waits a fixed
// settle time, captures both output pairs and returns accurate results with var-acc differences.
module arf_eval_ctrl
  import arf_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SUM_W         = 48,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  arf_eval_ctrl_if.slave          bus,
  output logic [NUM_IN*WORD-1:0]  dp_in_o,
  input  logic [NUM_OUT*WORD-1:0] dp_var_i,
  input  logic [NUM_OUT*WORD-1:0] dp_acc_i,
  input  logic                    clear_stats_i,
  output logic [WORD-1:0]         err_max_o,
  output logic [SUM_W-1:0]        err_sum_o,
  output logic [CNT_W-1:0]        sample_cnt_o
);

  localparam int CNT_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(SETTLE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic                    inReady_q, inReady_d;
  logic                    resValid_q, resValid_d;
  logic [NUM_IN*WORD-1:0]  dpIn_q, dpIn_d;
  logic [NUM_OUT*WORD-1:0] resAcc_q, resAcc_d;
  logic [NUM_OUT*WORD-1:0] resDiff_q, resDiff_d;
  logic                    capture;
  logic [NUM_OUT*WORD-1:0] diff;

  assign diff[OUT_27*WORD +: WORD] = dp_var_i[OUT_27*WORD +: WORD] - dp_acc_i[OUT_27*WORD +: WORD];
  assign diff[OUT_28*WORD +: WORD] = dp_var_i[OUT_28*WORD +: WORD] - dp_acc_i[OUT_28*WORD +: WORD];

  // in_ready is registered so it stays low while reset is held and rises on the first clean edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    resValid_d = resValid_q;
    dpIn_d     = dpIn_q;
    resAcc_d   = resAcc_q;
    resDiff_d  = resDiff_q;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && inReady_q) begin
          dpIn_d  = bus.in_data;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          capture    = 1'b1;
          resAcc_d   = dp_acc_i;
          resDiff_d  = diff;
          resValid_d = 1'b1;
          state_d    = RESULT;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          resValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    inReady_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inReady_q  <= 1'b0;
      resValid_q <= 1'b0;
      dpIn_q     <= '0;
      resAcc_q   <= '0;
      resDiff_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inReady_q  <= inReady_d;
      resValid_q <= resValid_d;
      dpIn_q     <= dpIn_d;
      resAcc_q   <= resAcc_d;
      resDiff_q  <= resDiff_d;
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.res_valid = resValid_q;
  assign bus.res_acc   = resAcc_q;
  assign bus.res_diff  = resDiff_q;
  assign dp_in_o       = dpIn_q;

  arf_err_stats #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_stats (
    .clk          (clk),
    .rst          (rst),
    .capture_i    (capture),
    .clear_i      (clear_stats_i),
    .diff_i       (diff),
    .err_max_o    (err_max_o),
    .err_sum_o    (err_sum_o),
    .sample_cnt_o (sample_cnt_o)
  );

endmodule

// File: tb/tb_arf_eval_ctrl.sv
// Directed bench for arf_eval_ctrl; datapaths stubbed as acc={in_2_0,in_1_0}, var={in_4_0,in_3_0}.
module tb_arf_eval_ctrl;
  import arf_pkg::*;

  logic                    clk;
  logic                    rst;
  logic [NUM_IN*WORD-1:0]  dp_in;
  logic [NUM_OUT*WORD-1:0] dp_var;
  logic [NUM_OUT*WORD-1:0] dp_acc;
  logic                    clear_stats;
  logic [WORD-1:0]         err_max;
  logic [47:0]             err_sum;
  logic [15:0]             sample_cnt;

  int testsRun;
  int testsFailed;

  arf_eval_ctrl_if bus ();

  arf_eval_ctrl #(
    .SETTLE_CYCLES (4),
    .SUM_W         (48),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .dp_in_o       (dp_in),
    .dp_var_i      (dp_var),
    .dp_acc_i      (dp_acc),
    .clear_stats_i (clear_stats),
    .err_max_o     (err_max),
    .err_sum_o     (err_sum),
    .sample_cnt_o  (sample_cnt)
  );

  assign dp_acc = {dp_in[1*WORD +: WORD], dp_in[0 +: WORD]};
  assign dp_var = {dp_in[3*WORD +: WORD], dp_in[2*WORD +: WORD]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Packs a sample: acc27, acc28, var27, var28 in words 0..3, recognisable filler above
  function automatic logic [NUM_IN*WORD-1:0] mk(input logic [31:0] a27, input logic [31:0] a28,
                                                input logic [31:0] v27, input logic [31:0] v28);
    logic [NUM_IN*WORD-1:0] d;
    d = '0;
    d[0*WORD +: WORD] = a27;
    d[1*WORD +: WORD] = a28;
    d[2*WORD +: WORD] = v27;
    d[3*WORD +: WORD] = v28;
    for (int i = 4; i < NUM_IN; i++) d[i*WORD +: WORD] = 32'hA5A0_0000 + 32'(i);
    return d;
  endfunction

  task automatic run_sample(input logic [NUM_IN*WORD-1:0] data);
    int lat;
    testsRun++;
    if (bus.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pre_accept_ready: got %b expected 1", bus.in_ready);
    end
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    testsRun++;
    if (dp_in !== data) begin
      testsFailed++;
      $display("[TB] FAIL dp_in_launch: got %h expected %h", dp_in, data);
    end
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    testsRun++;
    if (lat != 4) begin
      testsFailed++;
      $display("[TB] FAIL capture_latency: got %0d edges expected 4", lat);
    end
  endtask

  task automatic finish_result();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    testsRun++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL result_handshake: got valid=%b ready=%b expected valid=0 ready=1",
               bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    testsRun++;
    if ({bus.in_ready, bus.res_valid, err_max, sample_cnt} !== '0 || dp_in !== '0 ||
        err_sum !== '0 || bus.res_acc !== '0 || bus.res_diff !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b cnt=%h max=%h expected all 0",
               bus.in_ready, bus.res_valid, sample_cnt, err_max);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    testsRun++;
    if (bus.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready_rise: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_equal();
    run_sample(mk(32'd7, 32'd9, 32'd7, 32'd9));
    testsRun++;
    if (bus.res_diff !== 64'h0 || bus.res_acc !== {32'd9, 32'd7}) begin
      testsFailed++;
      $display("[TB] FAIL equal_result: got acc=%h diff=%h expected acc=%h diff=0",
               bus.res_acc, bus.res_diff, {32'd9, 32'd7});
    end
    testsRun++;
    if (err_max !== 32'h0 || err_sum !== 48'h0 || sample_cnt !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL equal_stats: got max=%h sum=%h cnt=%0d expected 0 0 1",
               err_max, err_sum, sample_cnt);
    end
    finish_result();
  endtask

  task automatic test_diff();
    run_sample(mk(32'd13, 32'd5, 32'd10, 32'd5));
    testsRun++;
    if (bus.res_diff !== {32'h0, 32'hFFFF_FFFD} || bus.res_acc !== {32'd5, 32'd13}) begin
      testsFailed++;
      $display("[TB] FAIL diff_result: got acc=%h diff=%h expected diff=%h",
               bus.res_acc, bus.res_diff, {32'h0, 32'hFFFF_FFFD});
    end
    testsRun++;
    if (err_max !== 32'd3 || err_sum !== 48'd3 || sample_cnt !== 16'd2) begin
      testsFailed++;
      $display("[TB] FAIL diff_stats: got max=%h sum=%h cnt=%0d expected 3 3 2",
               err_max, err_sum, sample_cnt);
    end
    finish_result();
  endtask

  task automatic test_min_neg();
    run_sample(mk(32'h0, 32'h1234, 32'h8000_0000, 32'h1234));
    testsRun++;
    if (bus.res_diff !== {32'h0, 32'h8000_0000}) begin
      testsFailed++;
      $display("[TB] FAIL minneg_diff: got %h expected %h", bus.res_diff, {32'h0, 32'h8000_0000});
    end
    testsRun++;
    if (err_max !== 32'h7FFF_FFFF || err_sum !== 48'h8000_0002 || sample_cnt !== 16'd3) begin
      testsFailed++;
      $display("[TB] FAIL minneg_stats: got max=%h sum=%h cnt=%0d expected 7fffffff 80000002 3",
               err_max, err_sum, sample_cnt);
    end
    finish_result();
  endtask

  task automatic test_hold();
    logic [NUM_IN*WORD-1:0] data;
    logic [NUM_IN*WORD-1:0] other;
    int bad;
    data  = mk(32'd100, 32'd50, 32'd90, 32'd70);
    other = mk(32'd1, 32'd2, 32'd3, 32'd4);
    run_sample(data);
    bus.in_data  = other;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || dp_in !== data ||
          bus.res_acc !== {32'd50, 32'd100} || bus.res_diff !== {32'd20, 32'hFFFF_FFF6}) bad++;
    end
    bus.in_valid = 1'b0;
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0 (diff=%h)", bad, bus.res_diff);
    end
    finish_result();
    testsRun++;
    if (sample_cnt !== 16'd4 || err_sum !== 48'h8000_0020 || err_max !== 32'h7FFF_FFFF ||
        dp_in !== data) begin
      testsFailed++;
      $display("[TB] FAIL hold_stats: got cnt=%0d sum=%h max=%h expected 4 80000020 7fffffff",
               sample_cnt, err_sum, err_max);
    end
  endtask

  task automatic test_clear_on_capture();
    bus.in_data  = mk(32'd1, 32'd8, 32'd4, 32'd2);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    testsRun++;
    if (err_max !== 32'h0 || err_sum !== 48'h0 || sample_cnt !== 16'd0) begin
      testsFailed++;
      $display("[TB] FAIL clear_stats: got max=%h sum=%h cnt=%0d expected 0 0 0",
               err_max, err_sum, sample_cnt);
    end
    testsRun++;
    if (bus.res_valid !== 1'b1 || bus.res_diff !== {32'hFFFF_FFFA, 32'd3} ||
        bus.res_acc !== {32'd8, 32'd1}) begin
      testsFailed++;
      $display("[TB] FAIL clear_result: got valid=%b diff=%h expected 1 %h",
               bus.res_valid, bus.res_diff, {32'hFFFF_FFFA, 32'd3});
    end
    finish_result();
  endtask

  task automatic test_after_clear();
    run_sample(mk(32'd5, 32'd0, 32'd5, 32'h10));
    testsRun++;
    if (err_max !== 32'h10 || err_sum !== 48'h10 || sample_cnt !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL after_clear_stats: got max=%h sum=%h cnt=%0d expected 10 10 1",
               err_max, err_sum, sample_cnt);
    end
    finish_result();
  endtask

  task automatic test_reset_mid();
    bus.in_data  = mk(32'd3, 32'd3, 32'd9, 32'd9);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    testsRun++;
    if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || dp_in !== '0 ||
        err_max !== '0 || err_sum !== '0 || sample_cnt !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset: got ready=%b valid=%b cnt=%0d max=%h expected all 0",
               bus.in_ready, bus.res_valid, sample_cnt, err_max);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    testsRun++;
    if (bus.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midrun_ready: got %b expected 1", bus.in_ready);
    end
    repeat (6) @(posedge clk);
    #1;
    testsRun++;
    if (bus.res_valid !== 1'b0 || sample_cnt !== 16'd0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_no_result: got valid=%b cnt=%0d expected 0 0",
               bus.res_valid, sample_cnt);
    end
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rst          = 1'b1;
    clear_stats  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.res_ready = 1'b0;

    test_reset();
    test_equal();
    test_diff();
    test_min_neg();
    test_hold();
    test_clear_on_capture();
    test_after_clear();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
